// File: rtl/puzzle_checker.sv
// puzzle_checker: self-check harness for one solved-puzzle board.
// It launches a single run with a start pulse, logs each colour change seen
// on colour until stopped rises, then compares the log with EXP_PATTERN.
//
// Optional feature (macro PUZZLE_CHECKER_TIMEOUT_EN): a RUN-state watchdog.
// It ends a run that exceeds TIMEOUT clocks and reports timeout/fail. When
// the macro is undefined, no counter is built and o_timeout is tied to 0.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_go         run request, sampled in IDLE (and in DONE after a low clock)
//   o_start      launch pulse to the puzzle, START_CYCLES clocks wide
//   i_stopped    puzzle halted (level, asynchronous, synchronized here)
//   i_colour     ball colour, 1 = blue (level, asynchronous, synchronized here)
//   o_busy       high in LAUNCH/RUN/CHECK
//   o_done       high in DONE
//   o_pass       result, valid while o_done
//   o_fail       result, valid while o_done
//   o_timeout    watchdog expired, valid while o_done
//   o_log_count  number of colour changes logged (saturates at LOG_DEPTH)
//   o_log_data   logged colours, bit i = colour after change i
module puzzle_checker #(
  parameter int unsigned          START_CYCLES = 2,
  parameter int unsigned          LOG_DEPTH    = 16,
  parameter int unsigned          EXP_LEN      = 0,
  parameter logic [LOG_DEPTH-1:0] EXP_PATTERN  = '0,
  parameter int unsigned          TIMEOUT      = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_go,
  output logic        o_start,
  input  logic        i_stopped,
  input  logic        i_colour,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [5:0]  o_log_count,
  output logic [31:0] o_log_data
);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StCheck, StDone} state_e;

  localparam logic [3:0]  StartLast = 4'(START_CYCLES - 1);
  localparam logic [5:0]  LogDepthW = 6'(LOG_DEPTH);
  localparam logic [5:0]  ExpLenW   = 6'(EXP_LEN);
  // With EXP_LEN = 0 the mask is empty, so only the count takes part.
  localparam logic [31:0] ExpMask   = 32'((64'd1 << EXP_LEN) - 64'd1);
  localparam logic [31:0] ExpPat    = 32'(EXP_PATTERN) & ExpMask;

  state_e      r_state;
  logic        r_stp_meta, r_stp_s;
  logic        r_col_meta, r_col_s;
  logic [3:0]  r_start_cnt;
  logic        r_col_ref;
  logic        r_ovf;
  logic        r_go_low;
  logic        r_wd_hit;
  logic        r_start, r_busy, r_done, r_pass, r_fail, r_timeout;
  logic [5:0]  r_log_count;
  logic [31:0] r_log_data;

  logic w_launch;
  logic w_change;
  logic w_wd_limit;
  logic w_pass;

  // DONE only re-arms after go has been seen low, so a held go cannot retrigger.
  assign w_launch = i_go && ((r_state == StIdle) || ((r_state == StDone) && r_go_low));
  assign w_change = (r_col_s != r_col_ref);
  assign w_pass   = !r_ovf && !r_wd_hit && (r_log_count == ExpLenW) &&
                    ((r_log_data & ExpMask) == ExpPat);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stp_meta <= 1'b0;
      r_stp_s    <= 1'b0;
      r_col_meta <= 1'b0;
      r_col_s    <= 1'b0;
    end else begin
      r_stp_meta <= i_stopped;
      r_stp_s    <= r_stp_meta;
      r_col_meta <= i_colour;
      r_col_s    <= r_col_meta;
    end
  end

`ifdef PUZZLE_CHECKER_TIMEOUT_EN
  localparam int unsigned     WdW    = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] r_wd_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_launch) begin
      r_wd_cnt <= '0;
    end else if (r_state == StRun) begin
      r_wd_cnt <= r_wd_cnt + WdW'(1);
    end
  end

  // True on the RUN clock in which the counter reaches TIMEOUT.
  assign w_wd_limit = (r_state == StRun) && (r_wd_cnt == WdLast);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_wd_limit       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_start_cnt <= '0;
      r_col_ref   <= 1'b0;
      r_ovf       <= 1'b0;
      r_go_low    <= 1'b0;
      r_wd_hit    <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_log_count <= '0;
      r_log_data  <= '0;
    end else begin
      if ((r_state == StDone) && !i_go) begin
        r_go_low <= 1'b1;
      end
      case (r_state)
        StIdle, StDone: begin
          if (w_launch) begin
            r_state     <= StLaunch;
            r_start_cnt <= '0;
            r_col_ref   <= r_col_s;
            r_ovf       <= 1'b0;
            r_go_low    <= 1'b0;
            r_wd_hit    <= 1'b0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_log_count <= '0;
            r_log_data  <= '0;
          end
        end
        StLaunch: begin
          if (r_start_cnt == StartLast) begin
            r_start <= 1'b0;
            r_state <= StRun;
          end else begin
            r_start_cnt <= r_start_cnt + 4'd1;
          end
        end
        StRun: begin
          // A change in the same clock as stp_s is still logged.
          if (w_change) begin
            r_col_ref <= r_col_s;
            if (r_log_count < LogDepthW) begin
              r_log_data[r_log_count[4:0]] <= r_col_s;
              r_log_count                  <= r_log_count + 6'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          if (r_stp_s) begin
            r_state <= StCheck;
          end else if (w_wd_limit) begin
            r_wd_hit <= 1'b1;
            r_state  <= StCheck;
          end
        end
        StCheck: begin
          r_state   <= StDone;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_pass    <= w_pass;
          r_fail    <= !w_pass;
          r_timeout <= r_wd_hit;
        end
        default: begin
          r_state <= StIdle;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_start     = r_start;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_timeout   = r_timeout;
  assign o_log_count = r_log_count;
  assign o_log_data  = r_log_data;

endmodule
